hdr_bf_dispatch: RTL
====================

HDR_BF_DISPATCH -- requirements
Module: hdr_bf_dispatch

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2: number of bloom-filter lookup lanes, 1..8.
REQ-002 SHALL have parameter HDR_W, default 104: header width, packed {src_ip[103:72], dst_ip[71:40], protocol[39:32], src_port[31:16], dst_port[15:0]}.
REQ-003 SHALL have parameter TAG_W, default 8: packet tag width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum number of lane wait cycles, 1..65535.
REQ-005 SHALL have parameter FAIL_OPEN, default 0: safe bit reported on timeout.
REQ-006 SHALL have port CLK, input, 1: clock; all logic is on the rising edge.
REQ-007 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports s_hdr_tdata (input, HDR_W), s_hdr_tag (input, TAG_W), s_hdr_tvalid (input, 1) and s_hdr_tready (output, 1): header stream from the packet datapath.
REQ-009 SHALL have ports lane_req_valid (output, NUM_LANES), lane_req_ready (input, NUM_LANES) and lane_req_hdr (output, NUM_LANES*HDR_W, lane i at slice i): lookup requests.
REQ-010 SHALL have ports lane_res_valid (input, NUM_LANES) and lane_res (input, NUM_LANES, 1=possibly safe): lookup results.
REQ-011 SHALL have ports m_res_tdata (output, 2, {timeout, safe}), m_res_tag (output, TAG_W), m_res_tvalid (output, 1) and m_res_tready (input, 1): result stream.
REQ-012 SHALL have port stat_timeouts, output, 16: saturating count of timed-out lookups.

Function
REQ-013 Each lane SHALL have a state machine with states IDLE, REQ, WAIT and DONE, and SHALL store its own header, tag and result.
REQ-014 A header SHALL be accepted when s_hdr_tvalid && s_hdr_tready; s_hdr_tready SHALL be 1 exactly when at least one lane is IDLE.
REQ-015 On accept, the block SHALL choose a lane by round-robin among IDLE lanes, starting at the lane after the last granted lane (lane 0 after reset).
REQ-016 On accept, the chosen lane SHALL move IDLE->REQ, latch its header and tag, and push its index into an order FIFO of depth NUM_LANES.
REQ-017 In REQ, lane_req_valid[i] SHALL be 1 with lane_req_hdr stable; when lane_req_ready[i]=1 the lane SHALL move REQ->WAIT and clear its wait counter.
REQ-018 The first lane_req_valid SHALL be asserted in the cycle after accept.
REQ-019 In WAIT, lane_res_valid[i]=1 SHALL capture lane_res[i] with timeout=0 and move the lane to DONE.
REQ-020 In WAIT, the counter SHALL increment every cycle; when it reaches TIMEOUT without a result, the lane SHALL move to DONE with timeout=1 and safe=FAIL_OPEN, and stat_timeouts SHALL increment, saturating at 16'hFFFF.
REQ-021 A result and the timeout arriving in the same cycle SHALL be treated as a result; the timeout is not counted.
REQ-022 lane_res_valid[i] SHALL be ignored while lane i is IDLE, REQ or DONE.
REQ-023 Results SHALL be emitted in accept order: when the lane at the order FIFO head is DONE, m_res_tvalid, m_res_tdata and m_res_tag SHALL be presented on a registered output in the next cycle.
REQ-024 m_res_tvalid SHALL stay at 1 with stable data until m_res_tready=1; on the handshake the FIFO SHALL pop and the lane SHALL return to IDLE.
REQ-025 A lane freed by a result handshake SHALL be eligible for accept in the following cycle, not in the same cycle.
REQ-026 A header accept and a result pop in the same cycle SHALL both take effect.
REQ-027 A DONE lane that is not at the FIFO head SHALL hold its result indefinitely; a later result SHALL never overtake an earlier one.

Reset
REQ-028 While RST_N=0, all lanes SHALL be IDLE and the order FIFO empty; s_hdr_tready=0, lane_req_valid=0, m_res_tvalid=0, m_res_tdata=0, m_res_tag=0, stat_timeouts=0; the round-robin pointer SHALL be 0.
REQ-029 s_hdr_tready SHALL rise to 1 in the first cycle after reset deassertion.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight lookups; no result for them SHALL be emitted afterwards.

Verification
REQ-031 Single header, tag 8'h11, lane 0 ready immediately, lane_res=1 after 3 cycles -> exactly one m_res with tag 8'h11, tdata 2'b01.
REQ-032 Tags 8'hA0 and 8'hA1 on lanes 0 and 1; lane 1 answers first with 0, lane 0 later with 1 -> output order A0 (2'b01) then A1 (2'b00).
REQ-033 TIMEOUT=4, FAIL_OPEN=0, lane never answers -> m_res tdata 2'b10 and stat_timeouts=1; a late lane_res_valid is ignored.
REQ-034 All lanes busy -> s_hdr_tready=0; with m_res_tready held 0, no header is accepted and results stay stable; after release, accept resumes one cycle after the pop.
REQ-035 Reset pulsed while two lookups are in WAIT -> no m_res_tvalid until new headers arrive, and stat_timeouts=0.

Source files
------------

// File: rtl/hdr_bf_dispatch.sv
// Header dispatcher to NUM_LANES bloom-filter lookup lanes. Results are returned
// strictly in accept order through a registered valid/ready output stage.
module hdr_bf_dispatch #(
    parameter int NUM_LANES = 2,
    parameter int HDR_W     = 104,
    parameter int TAG_W     = 8,
    parameter int TIMEOUT   = 255,
    parameter bit FAIL_OPEN = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [HDR_W-1:0]           s_hdr_tdata,
    input  logic [TAG_W-1:0]           s_hdr_tag,
    input  logic                       s_hdr_tvalid,
    output logic                       s_hdr_tready,
    output logic [NUM_LANES-1:0]       lane_req_valid,
    input  logic [NUM_LANES-1:0]       lane_req_ready,
    output logic [NUM_LANES*HDR_W-1:0] lane_req_hdr,
    input  logic [NUM_LANES-1:0]       lane_res_valid,
    input  logic [NUM_LANES-1:0]       lane_res,
    output logic [1:0]                 m_res_tdata,
    output logic [TAG_W-1:0]           m_res_tag,
    output logic                       m_res_tvalid,
    input  logic                       m_res_tready,
    output logic [15:0]                stat_timeouts,
    output logic [NUM_LANES*2-1:0]     dbg_lane_state
);

    // Every handshake (s_hdr, lane_req, m_res) transfers on a rising CLK edge where
    // valid and ready are both 1; valid never waits on ready and data holds while valid.

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(NUM_LANES + 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} lane_state_t;

    lane_state_t        lane_state [NUM_LANES];
    logic [HDR_W-1:0]   lane_hdr   [NUM_LANES];
    logic [TAG_W-1:0]   lane_tag   [NUM_LANES];
    logic               lane_safe  [NUM_LANES];
    logic               lane_to    [NUM_LANES];
    logic [15:0]        lane_cnt   [NUM_LANES];

    logic [LW-1:0]      order_q [NUM_LANES];
    logic [LW-1:0]      wr_ptr, rd_ptr, rr_ptr, grant_idx, head;
    logic [CW-1:0]      order_cnt;
    logic               in_service, any_idle, accept, pop, head_done;
    logic [NUM_LANES-1:0] to_hit;
    logic [16:0]        stat_sum;
    int                 idx;

    function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] p);
        return (int'(p) == NUM_LANES - 1) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starts at the lane after the last grant.
    always_comb begin
        any_idle  = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_LANES;
            if (!any_idle && lane_state[idx] == IDLE) begin
                any_idle  = 1'b1;
                grant_idx = LW'(idx);
            end
        end
    end

    always_comb begin
        lane_req_valid = '0;
        lane_req_hdr   = '0;
        dbg_lane_state = '0;
        to_hit         = '0;
        stat_sum       = {1'b0, stat_timeouts};
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_req_valid[i]              = (lane_state[i] == REQ);
            lane_req_hdr[i*HDR_W +: HDR_W] = lane_hdr[i];
            dbg_lane_state[i*2 +: 2]       = lane_state[i];
            to_hit[i] = (lane_state[i] == WAIT) && !lane_res_valid[i] && (lane_cnt[i] == TO_LAST);
            stat_sum  = stat_sum + 17'(to_hit[i]);
        end
    end

    // in_service keeps ready low during reset even though every lane reads IDLE.
    assign s_hdr_tready = in_service && any_idle;
    assign accept       = s_hdr_tvalid && s_hdr_tready;
    assign pop          = m_res_tvalid && m_res_tready;
    assign head         = order_q[rd_ptr];
    assign head_done    = (order_cnt != '0) && (lane_state[head] == DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state[i] <= IDLE;
                lane_hdr[i]   <= '0;
                lane_tag[i]   <= '0;
                lane_safe[i]  <= 1'b0;
                lane_to[i]    <= 1'b0;
                lane_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                case (lane_state[i])
                    IDLE: if (accept && int'(grant_idx) == i) begin
                        lane_state[i] <= REQ;
                        lane_hdr[i]   <= s_hdr_tdata;
                        lane_tag[i]   <= s_hdr_tag;
                    end
                    REQ: if (lane_req_ready[i]) begin
                        lane_state[i] <= WAIT;
                        lane_cnt[i]   <= '0;
                    end
                    WAIT: if (lane_res_valid[i]) begin
                        lane_state[i] <= DONE;
                        lane_safe[i]  <= lane_res[i];
                        lane_to[i]    <= 1'b0;
                    end else if (lane_cnt[i] == TO_LAST) begin
                        lane_state[i] <= DONE;
                        lane_safe[i]  <= FAIL_OPEN;
                        lane_to[i]    <= 1'b1;
                    end else begin
                        lane_cnt[i]   <= lane_cnt[i] + 16'd1;
                    end
                    DONE: if (pop && int'(head) == i) lane_state[i] <= IDLE;
                    default: lane_state[i] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_LANES; i++) order_q[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rr_ptr        <= '0;
            order_cnt     <= '0;
            in_service    <= 1'b0;
            m_res_tvalid  <= 1'b0;
            m_res_tdata   <= '0;
            m_res_tag     <= '0;
            stat_timeouts <= '0;
        end else begin
            in_service    <= 1'b1;
            order_cnt     <= order_cnt + CW'(accept) - CW'(pop);
            stat_timeouts <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
            if (accept) begin
                order_q[wr_ptr] <= grant_idx;
                wr_ptr          <= next_lane(wr_ptr);
                rr_ptr          <= next_lane(grant_idx);
            end
            if (pop) begin
                rd_ptr       <= next_lane(rd_ptr);
                m_res_tvalid <= 1'b0;
            end else if (!m_res_tvalid && head_done) begin
                m_res_tvalid <= 1'b1;
                m_res_tdata  <= {lane_to[head], lane_safe[head]};
                m_res_tag    <= lane_tag[head];
            end
        end
    end

endmodule
